// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] PC_INC     = 32'd4;
  localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: PC update, imem request/ack handshake and
// IF/ID valid/ready hand-off, with redirects accepted at any point after IDLE.
//
// state | meaning
// IDLE  | one cycle after reset, latches pc_i as the first fetch address
// FETCH | request outstanding at addr_q until ack (kill = discard that ack)
// HOLD  | fetched instruction buffered, offered to IF/ID
module fetch_ctrl
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rstn,
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] npc_o,
  output logic            pc_en_o,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            if_valid_o,
  input  logic            if_ready_i,
  output logic [XLEN-1:0] if_inst_o,
  output logic [XLEN-1:0] if_pc_o
);

  state_t          state;
  logic            kill;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] inst_q;
  logic [XLEN-1:0] pc_q;

  logic redir_act;
  logic accept;

  assign redir_act = redirect_i && (state != IDLE);
  assign accept    = (state == HOLD) && !redirect_i && if_ready_i;

  assign npc_o       = redir_act ? (redirect_pc_i & ALIGN_MASK) : (pc_q + PC_INC);
  assign pc_en_o     = redir_act || accept;
  assign imem_req_o  = (state == FETCH);
  assign imem_addr_o = addr_q;
  assign if_valid_o  = (state == HOLD) && !redirect_i;
  assign if_inst_o   = inst_q;
  assign if_pc_o     = pc_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      kill   <= 1'b0;
      addr_q <= '0;
      inst_q <= '0;
      pc_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          state  <= FETCH;
          addr_q <= pc_i;
        end
        FETCH: begin
          if (imem_ack_i) begin
            if (kill || redirect_i) begin
              // stale data: refetch from the PC the redirect has just loaded
              kill   <= 1'b0;
              addr_q <= pc_en_o ? npc_o : pc_i;
            end else begin
              inst_q <= imem_rdata_i;
              pc_q   <= addr_q;
              state  <= HOLD;
            end
          end else if (redirect_i) begin
            kill <= 1'b1;
          end
        end
        HOLD: begin
          if (pc_en_o) begin
            state  <= FETCH;
            addr_q <= npc_o;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus randomized traffic against a
// program-order scoreboard, a PC-register model and a variable-latency memory.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  logic            clk;
  logic            rstn;
  logic [XLEN-1:0] pc_i;
  logic [XLEN-1:0] npc_o;
  logic            pc_en_o;
  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_ack_i;
  logic [XLEN-1:0] imem_rdata_i;
  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            if_valid_o;
  logic            if_ready_i;
  logic [XLEN-1:0] if_inst_o;
  logic [XLEN-1:0] if_pc_o;

  fetch_ctrl dut (
    .clk(clk), .rstn(rstn), .pc_i(pc_i), .npc_o(npc_o), .pc_en_o(pc_en_o),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i),
    .imem_rdata_i(imem_rdata_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .if_valid_o(if_valid_o), .if_ready_i(if_ready_i), .if_inst_o(if_inst_o), .if_pc_o(if_pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          mem_wait = 0;
  int          cnt;
  int          stall = 0;
  logic        rdy = 1'b1;
  logic        redir = 1'b0;
  logic [31:0] redir_tgt = '0;
  logic [31:0] exp_next = '0;
  logic        prev_pend = 1'b0;
  logic [31:0] prev_addr = '0;
  logic        pc_set = 1'b0;
  logic [31:0] pc_set_val = '0;
  logic [31:0] pc_reg;
  logic        got_ack;

  assign pc_i = pc_reg;

  // External PC register
  always @(posedge clk) begin
    if (pc_en_o) pc_reg <= npc_o;
    else if (pc_set) pc_reg <= pc_set_val;
  end

  // Memory latency counter: ack once the request has waited mem_wait cycles
  always @(posedge clk or negedge rstn) begin
    if (!rstn) cnt <= 0;
    else if (imem_req_o && !imem_ack_i) cnt <= cnt + 1;
    else cnt <= 0;
  end

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    imem_ack_i    = imem_req_o && (cnt >= mem_wait);
    imem_rdata_i  = imem_ack_i ? memf(imem_addr_o) : $urandom;
    if_ready_i    = rdy;
    redirect_i    = redir;
    redirect_pc_i = redir_tgt;
    #1;
    if (prev_pend) begin
      chk("req_hold", {31'd0, imem_req_o}, 1);
      chk("addr_hold", imem_addr_o, prev_addr);
    end
    if (redir) begin
      chk("redir_en", {31'd0, pc_en_o}, 1);
      chk("redir_npc", npc_o, {redir_tgt[31:2], 2'b00});
      chk("redir_valid", {31'd0, if_valid_o}, 0);
      exp_next = {redir_tgt[31:2], 2'b00};
      stall = 0;
    end else if (if_valid_o && rdy) begin
      chk("if_pc", if_pc_o, exp_next);
      chk("if_inst", if_inst_o, memf(exp_next));
      chk("acc_en", {31'd0, pc_en_o}, 1);
      chk("acc_npc", npc_o, exp_next + 32'd4);
      exp_next = exp_next + 32'd4;
      stall = 0;
    end else begin
      chk("quiet_en", {31'd0, pc_en_o}, 0);
      stall++;
    end
    if (stall > 60) begin
      chk("progress_stall", stall, 0);
      stall = 0;
    end
    prev_pend = imem_req_o && !imem_ack_i;
    prev_addr = imem_addr_o;
  endtask

  // Entered just after a negedge; leaves at the IDLE cycle with checks done.
  task automatic do_reset(input logic [31:0] start_pc);
    rstn = 1'b0;
    redir = 1'b0;
    redirect_i = 1'b0;
    imem_ack_i = 1'b1;
    pc_set = 1'b1;
    pc_set_val = start_pc;
    #1;
    chk("rst_req_async", {31'd0, imem_req_o}, 0);
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, if_valid_o}, 0);
    rstn = 1'b1;
    pc_set = 1'b0;
    #1;
    chk("idle_req", {31'd0, imem_req_o}, 0);
    chk("idle_en", {31'd0, pc_en_o}, 0);
    chk("idle_npc", npc_o, 4);
    chk("idle_valid", {31'd0, if_valid_o}, 0);
    prev_pend = 1'b0;
    exp_next = start_pc;
    stall = 0;
  endtask

  initial begin
    rstn = 1'b1;
    imem_ack_i = 1'b0;
    imem_rdata_i = '0;
    redirect_i = 1'b0;
    redirect_pc_i = '0;
    if_ready_i = 1'b1;
    #2;
    mem_wait = 0;
    rdy = 1'b1;
    do_reset(32'h0);

    // zero-wait fetch
    cycle();
    chk("t1_req", {31'd0, imem_req_o}, 1);
    chk("t1_addr", imem_addr_o, 32'h0);
    cycle();
    chk("t1_valid", {31'd0, if_valid_o}, 1);
    chk("t1_pc", if_pc_o, 32'h0);
    chk("t1_en", {31'd0, pc_en_o}, 1);
    chk("t1_npc", npc_o, 32'h4);

    // 3-wait memory, redirect in the second wait cycle
    mem_wait = 3;
    redir_tgt = 32'h100;
    got_ack = 1'b0;
    for (int k = 0; k < 8; k++) begin
      redir = (k == 1);
      cycle();
      chk("t2_addr", imem_addr_o, 32'h4);
      chk("t2_valid", {31'd0, if_valid_o}, 0);
      if (k == 1) chk("t2_npc", npc_o, 32'h100);
      if (imem_ack_i) begin
        got_ack = 1'b1;
        break;
      end
    end
    redir = 1'b0;
    chk("t2_ack_seen", {31'd0, got_ack}, 1);
    mem_wait = 0;
    rdy = 1'b0;
    cycle();
    chk("t2_next_req", {31'd0, imem_req_o}, 1);
    chk("t2_next_addr", imem_addr_o, 32'h100);

    // back-pressure in HOLD
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("t3_valid", {31'd0, if_valid_o}, 1);
      chk("t3_pc", if_pc_o, 32'h100);
      chk("t3_inst", if_inst_o, memf(32'h100));
      chk("t3_req", {31'd0, imem_req_o}, 0);
    end
    rdy = 1'b1;
    cycle();
    chk("t3_npc", npc_o, 32'h104);
    cycle();
    chk("t3_next_addr", imem_addr_o, 32'h104);

    // redirect with ready in HOLD
    redir = 1'b1;
    redir_tgt = 32'h200;
    cycle();
    chk("t4_valid", {31'd0, if_valid_o}, 0);
    chk("t4_npc", npc_o, 32'h200);

    // misaligned target on a same-cycle ack
    redir_tgt = 32'h103;
    cycle();
    chk("t4_next_addr", imem_addr_o, 32'h200);
    chk("t5_npc", npc_o, 32'h100);
    redir_tgt = 32'hFFFF_FFFF;
    cycle();
    chk("t5_next_addr", imem_addr_o, 32'h100);
    redir = 1'b0;
    cycle();
    chk("t5_top_addr", imem_addr_o, 32'hFFFF_FFFC);
    cycle();
    chk("t5_top_pc", if_pc_o, 32'hFFFF_FFFC);
    chk("t5_wrap_npc", npc_o, 32'h0);
    cycle();
    chk("t5_wrap_addr", imem_addr_o, 32'h0);

    // reset during an outstanding request
    mem_wait = 5;
    cycle();
    cycle();
    chk("t6_req_before", {31'd0, imem_req_o}, 1);
    mem_wait = 0;
    do_reset(32'h40);
    cycle();
    chk("t6_req", {31'd0, imem_req_o}, 1);
    chk("t6_addr", imem_addr_o, 32'h40);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (!prev_pend) mem_wait = $urandom_range(0, 3);
      rdy = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 9) == 0);
      redir_tgt = $urandom;
      cycle();
    end
    redir = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
